text_console_ctrl: RTL
======================

// Module: text_console_ctrl
// PURPOSE
//  Parametrised character-console engine behind the VGA text output path. Accepts a stream of
//  8-bit codes plus colour attribute over valid/ready, interprets control codes, maintains a
//  cursor and a circular screen buffer with hardware scrolling. Also serves a synchronous read
//  port addressed in on-screen coordinates to the pixel encoder.
// PARAMETERS
//  COLS       80        characters per row
//  ROWS       30        rows on screen
//  ATTR_W     8         attribute bits per cell (fg/bg colour index)
//  BLINK_DIV  25000000  clk cycles per cursor blink half-period
//  CLR_ATTR   8'h07     attribute written into cleared cells (cleared char = 8'h20)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high
//  cin        in   8       character / control code
//  cattr      in   ATTR_W  attribute stored with printable cin
//  cvalid     in   1       cin/cattr valid
//  cready     out  1       engine can accept a code this cycle
//  rd_col     in   clog2(COLS)  display column to read
//  rd_row     in   clog2(ROWS)  display row to read (0 = top of screen)
//  rd_char    out  8       character at (rd_col,rd_row), 1-cycle latency
//  rd_attr    out  ATTR_W  attribute at same cell, 1-cycle latency
//  cur_col    out  clog2(COLS)  cursor column
//  cur_row    out  clog2(ROWS)  cursor display row
//  cur_vis    out  1       cursor blink phase (1 = draw cursor)
//  busy       out  1       clear/scroll sweep in progress
// BEHAVIOUR
//  - One clock (clk); reset synchronous active-high. Reset: cur_col=0, cur_row=0, top=0,
//    cur_vis=1, blink counter=0, rd_char=0, rd_attr=0, state=CLR_ALL, busy=1, cready=0.
//  - Transfer occurs on cycle with cvalid&&cready; cready=1 only in IDLE. One code per cycle max.
//  - FSM: IDLE, CLR_LINE, CLR_ALL.
//    IDLE, printable (0x20..0x7E): write {cin,cattr} at cursor; cur_col++. If cur_col was COLS-1:
//      cur_col=0 and do NEWLINE.
//    IDLE, 0x0A or 0x0D: cur_col=0, NEWLINE.
//    IDLE, 0x08: if cur_col>0 cur_col--; else if cur_row>0 {cur_col=COLS-1, cur_row--};
//      else no-op. New position written with {8'h20,CLR_ATTR}.
//    IDLE, 0x0C: cur_col=cur_row=0, top=0, -> CLR_ALL.
//    IDLE, any other code: consumed, ignored.
//    NEWLINE: if cur_row<ROWS-1 cur_row++; else top=(top+1) mod ROWS, cur_row stays ROWS-1,
//      -> CLR_LINE.
//    CLR_LINE: writes blank cells to physical row (top+ROWS-1) mod ROWS, one cell/cycle, COLS
//      cycles, then IDLE. CLR_ALL: sweeps all ROWS*COLS cells, then IDLE.
//  - busy=1 exactly while in CLR_LINE/CLR_ALL; cready=!busy.
//  - Address map: phys_row=(row+top) mod ROWS, computed without a divider (compare/subtract,
//    valid because row,top<ROWS). Cell index = phys_row*COLS+col.
//  - Read port: registered, 1-cycle latency, always active (also during sweeps; returns
//    partially cleared content). Same-cycle read/write to one cell returns OLD data.
//  - Out-of-range rd_col>=COLS or rd_row>=ROWS: rd_char=8'h20, rd_attr=CLR_ATTR.
//  - Blink: counter wraps at BLINK_DIV-1 and toggles cur_vis. Any accepted code resets counter
//    and forces cur_vis=1.
//  - reset asserted mid-sweep or mid-transfer: abandons it; restarts CLR_ALL from cell 0.
// STRUCTURE
//  - console_pkg: control-code constants (CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D),
//    blank char 8'h20, FSM state encoding.
//  - Sub-module console_ram: simple dual-port RAM, ROWS*COLS x (8+ATTR_W), 1 write port,
//    1 sync read port, read-old-on-collision; infers BRAM.
//  - Top holds FSM, cursor/top registers, sweep counter, blink divider, address mapping.
// TESTING (COLS=80, ROWS=30, BLINK_DIV=16 in bench)
//  - Reset 1 cycle -> busy=1,cready=0 for 2400 cycles; then all 2400 reads give 8'h20/8'h07.
//  - Send "A"(attr 8'h1E) -> rd(0,0) = 8'h41/8'h1E one cycle after address; cur_col=1.
//  - Send 81 'x' from (0,0) -> row0 full, rd(0,1)='x', cur=(1,1).
//  - Cursor at row 29, send 0x0A -> busy for 80 cycles; old row1 now at display row0; row29 blank.
//  - At (0,0) send 0x08 -> no change; at (0,5) send 0x08 -> cur=(79,4), cell blank.
//  - No input 32 cycles -> cur_vis toggles at 16, 32; accepted code forces cur_vis=1.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console engine.
package console_pkg;

    localparam logic [7:0] CC_BS       = 8'h08;
    localparam logic [7:0] CC_LF       = 8'h0A;
    localparam logic [7:0] CC_FF       = 8'h0C;
    localparam logic [7:0] CC_CR       = 8'h0D;
    localparam logic [7:0] CH_BLANK    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_CLR_ALL  = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= CH_PRINT_LO) && (code <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/console_ram.sv
// Simple dual-port screen memory: one write port, one registered read port
// returning the old contents when both ports hit the same cell.
module console_ram #(
    parameter int DEPTH  = 2400,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port with synchronous output reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Character console engine: control-code interpretation, cursor tracking,
// circular screen buffer with hardware scroll and a display-coordinate read port.
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int                COLS      = 80,
    parameter int                ROWS      = 30,
    parameter int                ATTR_W    = 8,
    parameter int                BLINK_DIV = 25000000,
    parameter logic [ATTR_W-1:0] CLR_ATTR  = 8'h07
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                cin,
    input  logic [ATTR_W-1:0]         cattr,
    input  logic                      cvalid,
    output logic                      cready,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    output logic [7:0]                rd_char,
    output logic [ATTR_W-1:0]         rd_attr,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic                      cur_vis,
    output logic                      busy
);

    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int CELLS   = ROWS * COLS;
    localparam int ADDR_W  = $clog2(CELLS);
    localparam int DATA_W  = 8 + ATTR_W;
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    state_e             state_r, state_s;
    logic [COL_W-1:0]   cur_col_r, col_s;
    logic [ROW_W-1:0]   cur_row_r, row_s;
    logic [ROW_W-1:0]   top_r, top_s;
    logic [ADDR_W-1:0]  sweep_base_r, base_s;
    logic [ADDR_W-1:0]  sweep_cnt_r, cnt_s;
    logic [ADDR_W-1:0]  sweep_last_s;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               cur_vis_r;
    logic               rd_oor_r, rd_oor_s;
    logic [ADDR_W-1:0]  raddr_s;
    logic               we_s;
    logic [ADDR_W-1:0]  waddr_s;
    logic [DATA_W-1:0]  wdata_s;
    logic [DATA_W-1:0]  ram_q_s;
    logic               newline_s;
    logic               accept_s;

    // Display row -> physical row is a single conditional subtract since row,top < ROWS.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] top,
                                                    input logic [COL_W-1:0] col);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        sum = (sum >= (ROW_W+1)'(ROWS)) ? (sum - (ROW_W+1)'(ROWS)) : sum;
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign cready       = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign accept_s     = cvalid && cready;
    assign sweep_last_s = (state_r == ST_CLR_LINE) ? ADDR_W'(COLS - 1) : ADDR_W'(CELLS - 1);

    // next-state, cursor, scroll and write-port decode
    always_comb begin
        state_s   = state_r;
        col_s     = cur_col_r;
        row_s     = cur_row_r;
        top_s     = top_r;
        base_s    = sweep_base_r;
        cnt_s     = sweep_cnt_r;
        we_s      = 1'b0;
        waddr_s   = sweep_base_r + sweep_cnt_r;
        wdata_s   = {CH_BLANK, CLR_ATTR};
        newline_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cvalid) begin
                    if (is_printable(cin)) begin
                        we_s    = 1'b1;
                        waddr_s = cell_addr(cur_row_r, top_r, cur_col_r);
                        wdata_s = {cin, cattr};
                        if (cur_col_r == COL_LAST) begin
                            col_s     = '0;
                            newline_s = 1'b1;
                        end else begin
                            col_s = cur_col_r + COL_W'(1);
                        end
                    end else if ((cin == CC_LF) || (cin == CC_CR)) begin
                        col_s     = '0;
                        newline_s = 1'b1;
                    end else if (cin == CC_BS) begin
                        if (cur_col_r != '0) begin
                            col_s   = cur_col_r - COL_W'(1);
                            we_s    = 1'b1;
                            waddr_s = cell_addr(cur_row_r, top_r, cur_col_r - COL_W'(1));
                        end else if (cur_row_r != '0) begin
                            col_s   = COL_LAST;
                            row_s   = cur_row_r - ROW_W'(1);
                            we_s    = 1'b1;
                            waddr_s = cell_addr(cur_row_r - ROW_W'(1), top_r, COL_LAST);
                        end else begin
                            we_s = 1'b0;
                        end
                    end else if (cin == CC_FF) begin
                        col_s   = '0;
                        row_s   = '0;
                        top_s   = '0;
                        base_s  = '0;
                        cnt_s   = '0;
                        state_s = ST_CLR_ALL;
                    end else begin
                        we_s = 1'b0;
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
                we_s = 1'b1;
                if (sweep_cnt_r == sweep_last_s) begin
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = sweep_cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                base_s  = '0;
                cnt_s   = '0;
                state_s = ST_CLR_ALL;
            end
        endcase
        // Scrolling: the old top physical row becomes the new bottom row and is blanked.
        if (newline_s) begin
            if (cur_row_r != ROW_LAST) begin
                row_s = cur_row_r + ROW_W'(1);
            end else begin
                top_s   = (top_r == ROW_LAST) ? '0 : (top_r + ROW_W'(1));
                base_s  = ADDR_W'(top_r) * ADDR_W'(COLS);
                cnt_s   = '0;
                state_s = ST_CLR_LINE;
            end
        end else begin
            top_s = top_s;
        end
    end

    // FSM, cursor, scroll origin and sweep counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_CLR_ALL;
            cur_col_r    <= '0;
            cur_row_r    <= '0;
            top_r        <= '0;
            sweep_base_r <= '0;
            sweep_cnt_r  <= '0;
        end else begin
            state_r      <= state_s;
            cur_col_r    <= col_s;
            cur_row_r    <= row_s;
            top_r        <= top_s;
            sweep_base_r <= base_s;
            sweep_cnt_r  <= cnt_s;
        end
    end

    // cursor blink divider; any accepted code restarts the visible phase
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= '0;
            cur_vis_r   <= 1'b1;
        end else if (accept_s) begin
            blink_cnt_r <= '0;
            cur_vis_r   <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            cur_vis_r   <= ~cur_vis_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    assign rd_oor_s = ({1'b0, rd_col} >= (COL_W+1)'(COLS)) || ({1'b0, rd_row} >= (ROW_W+1)'(ROWS));
    assign raddr_s  = rd_oor_s ? '0 : cell_addr(rd_row, top_r, rd_col);

    // out-of-range flag aligned with the RAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_oor_r <= 1'b0;
        end else begin
            rd_oor_r <= rd_oor_s;
        end
    end

    console_ram #(
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (ram_q_s)
    );

    assign rd_char = rd_oor_r ? CH_BLANK : ram_q_s[DATA_W-1:ATTR_W];
    assign rd_attr = rd_oor_r ? CLR_ATTR : ram_q_s[ATTR_W-1:0];
    assign cur_col = cur_col_r;
    assign cur_row = cur_row_r;
    assign cur_vis = cur_vis_r;

endmodule
